// File: rtl/collision_checker_pkg.sv
// Shared definitions for the collision checker: slot field layout on the
// gamedata bus, scan FSM states and slot field helpers.
package collision_checker_pkg;

  localparam int CC_DATALEN = 48;
  localparam int CC_XLEN    = 10;
  localparam int CC_YLEN    = 10;

  // Slot layout, LSB first: x | y | width | height | type
  localparam int FLD_X_OFF    = 0;
  localparam int FLD_Y_OFF    = FLD_X_OFF + CC_XLEN;
  localparam int FLD_W_OFF    = FLD_Y_OFF + CC_YLEN;
  localparam int FLD_H_OFF    = FLD_W_OFF + CC_XLEN;
  localparam int FLD_TYPE_OFF = FLD_H_OFF + CC_YLEN;
  localparam int FLD_TYPE_LEN = CC_DATALEN - FLD_TYPE_OFF;

  localparam logic [FLD_TYPE_LEN-1:0] ENEMY_TYPE = FLD_TYPE_LEN'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } cc_state_e;

  typedef struct packed {
    logic [CC_XLEN-1:0] x;
    logic [CC_YLEN-1:0] y;
    logic [CC_XLEN-1:0] w;
    logic [CC_YLEN-1:0] h;
  } box_t;

  function automatic logic slot_is_enemy(input logic [CC_DATALEN-1:0] slot);
    return slot[FLD_TYPE_OFF +: FLD_TYPE_LEN] == ENEMY_TYPE;
  endfunction

  function automatic box_t slot_box(input logic [CC_DATALEN-1:0] slot);
    box_t b;
    b.x = slot[FLD_X_OFF +: CC_XLEN];
    b.y = slot[FLD_Y_OFF +: CC_YLEN];
    b.w = slot[FLD_W_OFF +: CC_XLEN];
    b.h = slot[FLD_H_OFF +: CC_YLEN];
    return b;
  endfunction

endpackage

// File: rtl/collision_checker_box_overlap.sv
// Combinational strict box overlap test. Right/bottom edges are computed one
// bit wider so boxes near the top of the coordinate range do not wrap.
// Touching edges do not overlap; any zero-sized box never overlaps.
module box_overlap #(
  parameter int XLEN = 10,
  parameter int YLEN = 10
) (
  input  logic [XLEN-1:0] ax_i,
  input  logic [YLEN-1:0] ay_i,
  input  logic [XLEN-1:0] aw_i,
  input  logic [YLEN-1:0] ah_i,
  input  logic [XLEN-1:0] bx_i,
  input  logic [YLEN-1:0] by_i,
  input  logic [XLEN-1:0] bw_i,
  input  logic [YLEN-1:0] bh_i,
  output logic            overlap_o
);

  logic [XLEN:0] a_right;
  logic [XLEN:0] b_right;
  logic [YLEN:0] a_bottom;
  logic [YLEN:0] b_bottom;
  logic          x_hit;
  logic          y_hit;
  logic          sized;

  assign a_right  = {1'b0, ax_i} + {1'b0, aw_i};
  assign b_right  = {1'b0, bx_i} + {1'b0, bw_i};
  assign a_bottom = {1'b0, ay_i} + {1'b0, ah_i};
  assign b_bottom = {1'b0, by_i} + {1'b0, bh_i};

  assign x_hit = ({1'b0, ax_i} < b_right)  && ({1'b0, bx_i} < a_right);
  assign y_hit = ({1'b0, ay_i} < b_bottom) && ({1'b0, by_i} < a_bottom);

  // The strict compare alone lets a zero-width box inside the other one through.
  assign sized = (aw_i != '0) && (ah_i != '0) && (bw_i != '0) && (bh_i != '0);

  assign overlap_o = sized && x_hit && y_hit;

endmodule

// File: rtl/collision_checker.sv
// Per-frame collision scan of the enemy slots against the dinosaur box.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for frame_tick; snapshot holds the last captured frame
//   ST_SCAN   | testing snapshot slot idx_q against the dino box, one per cycle
//   ST_REPORT | done pulse (plus hit pulse when found); game_over latched
module collision_checker
  import collision_checker_pkg::*;
#(
  parameter int SLOTS    = 4,
  parameter int SLOTBITS = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic                          clk3,
  input  logic                          rst_n,
  input  logic                          frame_tick,
  input  logic                          clear,
  input  logic [SLOTS*CC_DATALEN-1:0]   gamedata,
  input  logic [CC_XLEN-1:0]            dino_x,
  input  logic [CC_YLEN-1:0]            dino_y,
  input  logic [CC_XLEN-1:0]            dino_w,
  input  logic [CC_YLEN-1:0]            dino_h,
  output logic                          busy,
  output logic                          done,
  output logic                          hit,
  output logic [SLOTBITS-1:0]           hit_slot,
  output logic                          game_over,
  output logic                          overrun
);

  localparam logic [SLOTBITS-1:0] LAST_IDX = SLOTBITS'(SLOTS - 1);

  cc_state_e                     state_q, state_d;
  logic [SLOTBITS-1:0]           idx_q, idx_d;
  logic                          found_q, found_d;
  logic [SLOTBITS-1:0]           hit_slot_q, hit_slot_d;
  logic                          game_over_q, game_over_d;
  logic                          overrun_q, overrun_d;
  logic [SLOTS*CC_DATALEN-1:0]   snap_q, snap_d;
  box_t                          dino_q, dino_d;

  logic [CC_DATALEN-1:0]         slot_cur;
  box_t                          slot_b;
  logic                          slot_overlap;
  logic                          slot_hit;

  // Select the snapshot slot currently under test.
  always_comb begin
    slot_cur = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (idx_q == SLOTBITS'(s)) begin
        slot_cur = snap_q[s*CC_DATALEN +: CC_DATALEN];
      end
    end
  end

  assign slot_b = slot_box(slot_cur);

  box_overlap #(
    .XLEN (CC_XLEN),
    .YLEN (CC_YLEN)
  ) u_overlap (
    .ax_i      (dino_q.x),
    .ay_i      (dino_q.y),
    .aw_i      (dino_q.w),
    .ah_i      (dino_q.h),
    .bx_i      (slot_b.x),
    .by_i      (slot_b.y),
    .bw_i      (slot_b.w),
    .bh_i      (slot_b.h),
    .overlap_o (slot_overlap)
  );

  assign slot_hit = slot_is_enemy(slot_cur) && slot_overlap;

  // Next-state logic; clear overrides everything, including a pending report.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    found_d     = found_q;
    hit_slot_d  = hit_slot_q;
    game_over_d = game_over_q;
    overrun_d   = overrun_q;
    snap_d      = snap_q;
    dino_d      = dino_q;

    if (clear) begin
      state_d     = ST_IDLE;
      idx_d       = '0;
      found_d     = 1'b0;
      hit_slot_d  = '0;
      game_over_d = 1'b0;
      overrun_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (frame_tick && !game_over_q) begin
            snap_d   = gamedata;
            dino_d.x = dino_x;
            dino_d.y = dino_y;
            dino_d.w = dino_w;
            dino_d.h = dino_h;
            idx_d    = '0;
            found_d  = 1'b0;
            state_d  = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (frame_tick) begin
            overrun_d = 1'b1;
          end
          if (slot_hit && !found_q) begin
            found_d    = 1'b1;
            hit_slot_d = idx_q;
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_REPORT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ST_REPORT: begin
          if (found_q) begin
            game_over_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and snapshot registers.
  always_ff @(posedge clk3 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      found_q     <= 1'b0;
      hit_slot_q  <= '0;
      game_over_q <= 1'b0;
      overrun_q   <= 1'b0;
      snap_q      <= '0;
      dino_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      found_q     <= found_d;
      hit_slot_q  <= hit_slot_d;
      game_over_q <= game_over_d;
      overrun_q   <= overrun_d;
      snap_q      <= snap_d;
      dino_q      <= dino_d;
    end
  end

  // busy drops in the report cycle; a clear in that cycle swallows the report.
  assign busy      = (state_q == ST_SCAN);
  assign done      = (state_q == ST_REPORT) && !clear;
  assign hit       = done && found_q;
  assign hit_slot  = hit_slot_q;
  assign game_over = game_over_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_collision_checker.sv
// Bench for collision_checker: directed frame scenarios plus randomized
// frames checked against a slot-by-slot reference model.
module tb_collision_checker;

  localparam int NS  = 4;
  localparam int DL  = 48;
  localparam int GDW = NS * DL;

  logic           clk3 = 1'b0;
  logic           rst_n;
  logic           frame_tick;
  logic           clear;
  logic [GDW-1:0] gamedata;
  logic [9:0]     dino_x, dino_y, dino_w, dino_h;
  logic           busy, done, hit, game_over, overrun;
  logic [1:0]     hit_slot;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int m_hit_slot  = 0;
  bit m_game_over = 0;
  bit m_overrun   = 0;

  always #5 clk3 = ~clk3;

  collision_checker #(.SLOTS(NS)) dut (
    .clk3       (clk3),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .clear      (clear),
    .gamedata   (gamedata),
    .dino_x     (dino_x),
    .dino_y     (dino_y),
    .dino_w     (dino_w),
    .dino_h     (dino_h),
    .busy       (busy),
    .done       (done),
    .hit        (hit),
    .hit_slot   (hit_slot),
    .game_over  (game_over),
    .overrun    (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk3);
    #1;
  endtask

  function automatic logic [DL-1:0] mk_slot(input int typ, input int x, input int y,
                                            input int w, input int h);
    logic [DL-1:0] s;
    s = '0;
    s[9:0]   = 10'(x);
    s[19:10] = 10'(y);
    s[29:20] = 10'(w);
    s[39:30] = 10'(h);
    s[47:40] = 8'(typ);
    return s;
  endfunction

  function automatic bit boxes_meet(input int ax, input int ay, input int aw, input int ah,
                                    input int bx, input int by, input int bw, input int bh);
    if (aw == 0 || ah == 0 || bw == 0 || bh == 0) return 0;
    return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
  endfunction

  // First enemy slot overlapping the dino, or -1.
  function automatic int ref_scan(input logic [GDW-1:0] gd);
    logic [DL-1:0] w;
    for (int s = 0; s < NS; s++) begin
      w = gd[s*DL +: DL];
      if (w[47:40] == 8'd1 &&
          boxes_meet(int'(dino_x), int'(dino_y), int'(dino_w), int'(dino_h),
                     int'(w[9:0]), int'(w[19:10]), int'(w[29:20]), int'(w[39:30])))
        return s;
    end
    return -1;
  endfunction

  task automatic run_scan(input logic [GDW-1:0] gd, input logic [GDW-1:0] gd_mid,
                          input bit use_mid, input string tag);
    int es;
    es = ref_scan(gd);
    gamedata   = gd;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    if (use_mid) gamedata = gd_mid;
    for (int c = 1; c <= 4; c++) begin
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_done_early"}, done, 0);
      if (c < 4) step();
    end
    step();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_rep"}, busy, 0);
    chk({tag, "_hit"}, hit, (es >= 0));
    if (es >= 0) m_hit_slot = es;
    chk({tag, "_hit_slot"}, hit_slot, m_hit_slot);
    step();
    chk({tag, "_done_after"}, done, 0);
    chk({tag, "_hit_after"}, hit, 0);
    if (es >= 0) m_game_over = 1;
    chk({tag, "_game_over"}, game_over, m_game_over);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    m_game_over = 0;
    m_hit_slot  = 0;
    m_overrun   = 0;
    chk("clr_game_over", game_over, 0);
    chk("clr_hit_slot", hit_slot, 0);
    chk("clr_overrun", overrun, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_hit"}, hit, 0);
    chk({tag, "_hit_slot"}, hit_slot, 0);
    chk({tag, "_game_over"}, game_over, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  logic [GDW-1:0] gd_a, gd_b;
  int             n_done;

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; clear = 1'b0; gamedata = '0;
    dino_x = 10'd20; dino_y = 10'd100; dino_w = 10'd20; dino_h = 10'd20;
    step(); step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    // 1: enemy in slot 2 overlaps
    gd_a = '0;
    gd_a[2*DL +: DL] = mk_slot(1, 30, 105, 10, 15);
    run_scan(gd_a, gd_a, 0, "t1");
    chk("t1_slot_is_2", hit_slot, 2);
    do_clear();

    // 2: touching right edge only
    gd_a = '0;
    gd_a[0 +: DL] = mk_slot(1, 40, 100, 10, 10);
    run_scan(gd_a, gd_a, 0, "t2");
    chk("t2_no_game_over", game_over, 0);

    // 3: non-enemy overlap, far enemy, overlapping update mid-scan
    gd_a = '0;
    gd_a[1*DL +: DL] = mk_slot(0, 25, 105, 10, 10);
    gd_a[3*DL +: DL] = mk_slot(1, 200, 105, 10, 10);
    gd_b = '0;
    gd_b[1*DL +: DL] = mk_slot(1, 25, 105, 10, 10);
    gd_b[3*DL +: DL] = mk_slot(1, 25, 105, 10, 10);
    run_scan(gd_a, gd_b, 1, "t3");

    // 4: two overlapping enemies, first one reported; tick ignored while game_over
    gd_a = '0;
    gd_a[1*DL +: DL] = mk_slot(1, 25, 105, 5, 5);
    gd_a[3*DL +: DL] = mk_slot(1, 22, 102, 5, 5);
    run_scan(gd_a, gd_a, 0, "t4");
    chk("t4_slot_is_1", hit_slot, 1);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      chk("t4_ignored_busy", busy, 0);
      if (done) n_done++;
      step();
    end
    chk("t4_ignored_done", n_done, 0);
    do_clear();

    // 5: second tick during scan -> overrun, one done
    gd_a = '0;
    gamedata = gd_a;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    n_done = 0;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    m_overrun = 1;
    for (int c = 0; c < 8; c++) begin
      if (done) n_done++;
      step();
    end
    chk("t5_overrun", overrun, m_overrun);
    chk("t5_done_count", n_done, 1);
    do_clear();

    // 6a: reset mid-scan
    gd_a = '0;
    gd_a[2*DL +: DL] = mk_slot(1, 30, 105, 10, 15);
    gamedata = gd_a;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    step();
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) n_done++;
      step();
    end
    chk("t6_rst_no_done", n_done, 0);

    // 6b: clear in the report cycle of a hitting scan
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int c = 0; c < 4; c++) step();
    chk("t6_report_reached", done, 1);
    clear = 1'b1;
    #1;
    chk("t6_clr_done", done, 0);
    chk("t6_clr_hit", hit, 0);
    step();
    clear = 1'b0;
    m_game_over = 0; m_hit_slot = 0; m_overrun = 0;
    chk("t6_clr_game_over", game_over, 0);
    chk("t6_clr_hit_slot", hit_slot, 0);

    // Randomized frames, including wide coordinates and zero sizes
    for (int it = 0; it < 60; it++) begin
      bit far;
      far    = ($urandom_range(0, 3) == 0);
      dino_x = far ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 60));
      dino_y = 10'($urandom_range(0, 60));
      dino_w = 10'($urandom_range(0, 30));
      dino_h = 10'($urandom_range(0, 30));
      for (int s = 0; s < NS; s++) begin
        gd_a[s*DL +: DL] = mk_slot($urandom_range(0, 2),
                                   far ? $urandom_range(980, 1023) : $urandom_range(0, 80),
                                   $urandom_range(0, 80), $urandom_range(0, 30),
                                   $urandom_range(0, 30));
        gd_b[s*DL +: DL] = mk_slot(1, int'(dino_x), int'(dino_y), 20, 20);
      end
      run_scan(gd_a, gd_b, ($urandom_range(0, 1) == 1), "rnd");
      if (m_game_over) do_clear();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
